updown_ramp_sequencer: RTL
==========================

Name: updown_ramp_sequencer

Overview:
- Controller that sequences a shared synchronous up/down counter. The counter has `load`/`load_val`/`enable`/`up` controls and a `count` output.
- Each run produces a programmable triangle ramp: load `lo`, count up to `hi`, count back down to `lo`, repeated `reps` times, then signals done.
- Sits directly in front of the counter instance and drives all of its control inputs. The counter's `count` is fed back for limit detection.

Parameters:
- WIDTH, 4, counter/data width; must match the driven counter.
- REP_W, 8, width of the repetition count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- abort  input  1  terminate a run in progress.
- lo  input  WIDTH  lower ramp limit; sampled with start.
- hi  input  WIDTH  upper ramp limit; sampled with start.
- reps  input  REP_W  number of full up/down cycles; sampled with start.
- cnt_count  input  WIDTH  current counter value (feedback).
- cnt_load  output  1  counter load strobe.
- cnt_load_val  output  WIDTH  counter load value; always equals latched lo_q.
- cnt_enable  output  1  counter step enable.
- cnt_up  output  1  counter direction: 1 = up, 0 = down.
- busy  output  1  high in LOAD, UP, DOWN (and HOLD when the optional feature is compiled in).
- done  output  1  one-cycle pulse on normal completion.
- cfg_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; lo_q, hi_q and rep_cnt clear to 0.
  - All outputs 0, including cnt_load_val (lo_q=0).
- Output structure:
  - cnt_load, cnt_enable and cnt_up are combinational from state and cnt_count (Mealy), so the counter never overshoots a limit.
  - busy, done and cfg_err are decoded from registered state or flags.
- IDLE:
  - All counter controls are 0.
  - start=1 with lo<hi and reps!=0: latch lo_q/hi_q/reps_q, clear rep_cnt, go to LOAD.
  - start=1 with an invalid configuration: cfg_err=1 for the next cycle only; stay in IDLE.
- LOAD: cnt_load=1 for exactly one cycle, then go to UP. The counter holds lo_q on the first UP cycle.
- UP:
  - While cnt_count != hi_q: cnt_enable=1, cnt_up=1.
  - When cnt_count == hi_q: cnt_enable=1, cnt_up=0 (reverse immediately, peak lasts one cycle), then go to DOWN.
- DOWN:
  - While cnt_count != lo_q: cnt_enable=1, cnt_up=0.
  - When cnt_count == lo_q: rep_cnt increments.
    - If rep_cnt+1 == reps_q: cnt_enable=0, go to DONE.
    - Otherwise: cnt_enable=1, cnt_up=1, go to UP.
- DONE:
  - done=1 for one cycle, all counter controls 0, then go to IDLE.
  - The counter is left at lo_q.
- Resulting sequence: lo, lo+1 … hi … lo+1, lo, repeated; period 2*(hi-lo) cycles. The counter never wraps, because lo<hi is enforced.
- Run latency: done is high 2*(hi-lo)*reps + 2 clocks after the edge that sampled start.
- abort:
  - Effective in LOAD/UP/DOWN (and HOLD).
  - Combinationally forces cnt_load/cnt_enable to 0 in the same cycle; state goes to IDLE on the next edge.
  - No done pulse; the counter keeps its current value.
  - abort in IDLE or DONE is ignored. If abort and the final trough coincide, abort wins (no done).
- start while busy or in DONE: ignored; changes to lo/hi/reps during a run have no effect.
- Reset mid-run: immediate return to IDLE with all outputs 0. The counter is reset by its own reset.

Optional Feature:
- Macro: RAMP_DWELL_EN.
- When defined:
  - Adds input dwell (8 bits), sampled with start, and a HOLD state.
  - On reaching hi (in UP) or a non-final lo (in DOWN), the controller enters HOLD with cnt_enable=0 for dwell_q cycles, then issues the reversing step and continues.
  - dwell=0 behaves identically to the non-macro build.
  - Final trough goes straight to DONE with no dwell.
- When undefined: no dwell port, no HOLD state; behaviour exactly as above.

Test Plan:
- WIDTH=4, lo=2, hi=5, reps=2, start pulse -> cnt_count 2,3,4,5,4,3,2,3,4,5,4,3,2; done pulse 14 clocks after start sampled; busy high throughout the run; counter ends at 2.
- start with lo=5, hi=5 (and separately reps=0) -> cfg_err one-cycle pulse; cnt_load never asserted; busy stays 0.
- lo=0, hi=15, reps=1 -> counts 0…15…0 with no wrap; cnt_enable low in the DONE cycle; done after 32 clocks.
- abort asserted while cnt_count=4 during UP of the first case -> cnt_enable 0 in that cycle; IDLE next cycle; no done; count held at 4.
- start re-pulsed mid-run with different lo/hi -> ignored, sequence unchanged. rst_n low mid-DOWN -> all outputs 0 immediately; state IDLE.
- RAMP_DWELL_EN with dwell=3, lo=1, hi=3, reps=2 -> 1,2,3,3,3,3,2,1,1,1,1,2,3,3,3,3,2,1; then done.

Source files
------------

// File: rtl/updown_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : updown_ramp_sequencer
// Description : Drives an external up/down counter through a programmable
//               triangle ramp lo -> hi -> lo, repeated reps times, then
//               pulses done. Counter feedback (cnt_count) is used for limit
//               detection; the step controls are Mealy so a limit is never
//               overshot.
//               Optional macro RAMP_DWELL_EN adds a dwell input and a HOLD
//               state that pauses at each peak and non-final trough.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_ramp_sequencer #(
    parameter int WIDTH = 4,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [REP_W-1:0] reps,
`ifdef RAMP_DWELL_EN
    input  logic [7:0]       dwell,
`endif
    input  logic [WIDTH-1:0] cnt_count,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_enable,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4,
        S_HOLD = 3'd5
    } state_e;

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [REP_W-1:0] reps_q,    reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             cfg_err_q, cfg_err_d;
    logic [REP_W-1:0] w_rep_next;

`ifdef RAMP_DWELL_EN
    logic [7:0]       dwell_q,     dwell_d;
    logic [7:0]       dwell_cnt_q, dwell_cnt_d;
    logic             hold_dn_q,   hold_dn_d;   // 1: leave HOLD stepping down
`endif

    // Repetition count including the trough being reached now
    assign w_rep_next = rep_cnt_q + {{(REP_W-1){1'b0}}, 1'b1};

    // State and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            reps_q      <= '0;
            rep_cnt_q   <= '0;
            cfg_err_q   <= 1'b0;
`ifdef RAMP_DWELL_EN
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            hold_dn_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            reps_q      <= reps_d;
            rep_cnt_q   <= rep_cnt_d;
            cfg_err_q   <= cfg_err_d;
`ifdef RAMP_DWELL_EN
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            hold_dn_q   <= hold_dn_d;
`endif
        end
    end

    // Next-state logic and Mealy counter controls
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        reps_d      = reps_q;
        rep_cnt_d   = rep_cnt_q;
        cfg_err_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_enable  = 1'b0;
        cnt_up      = 1'b0;
`ifdef RAMP_DWELL_EN
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        hold_dn_d   = hold_dn_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((lo < hi) && (reps != '0)) begin
                        lo_d      = lo;
                        hi_d      = hi;
                        reps_d    = reps;
                        rep_cnt_d = '0;
`ifdef RAMP_DWELL_EN
                        dwell_d   = dwell;
`endif
                        state_d   = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = S_UP;
                end
            end

            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_count != hi_q) begin
                    cnt_enable = 1'b1;
                    cnt_up     = 1'b1;
                end else begin
`ifdef RAMP_DWELL_EN
                    if (dwell_q != 8'd0) begin
                        dwell_cnt_d = dwell_q;
                        hold_dn_d   = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        cnt_enable = 1'b1;
                        state_d    = S_DOWN;
                    end
`else
                    // Peak: reverse on the same cycle so hi lasts one cycle
                    cnt_enable = 1'b1;
                    state_d    = S_DOWN;
`endif
                end
            end

            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_count != lo_q) begin
                    cnt_enable = 1'b1;
                end else begin
                    rep_cnt_d = w_rep_next;
                    if (w_rep_next == reps_q) begin
                        state_d = S_DONE;
                    end else begin
`ifdef RAMP_DWELL_EN
                        if (dwell_q != 8'd0) begin
                            dwell_cnt_d = dwell_q;
                            hold_dn_d   = 1'b0;
                            state_d     = S_HOLD;
                        end else begin
                            cnt_enable = 1'b1;
                            cnt_up     = 1'b1;
                            state_d    = S_UP;
                        end
`else
                        cnt_enable = 1'b1;
                        cnt_up     = 1'b1;
                        state_d    = S_UP;
`endif
                    end
                end
            end

`ifdef RAMP_DWELL_EN
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_cnt_q == 8'd1) begin
                    // Last dwell cycle issues the reversing step
                    cnt_enable = 1'b1;
                    cnt_up     = ~hold_dn_q;
                    state_d    = hold_dn_q ? S_DOWN : S_UP;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 8'd1;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cnt_load_val = lo_q;
    assign busy         = (state_q == S_LOAD) || (state_q == S_UP) ||
                          (state_q == S_DOWN) || (state_q == S_HOLD);
    assign done         = (state_q == S_DONE);
    assign cfg_err      = cfg_err_q;

endmodule
`default_nettype wire
